fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-entry skid buffer and a kill state
// for redirects that arrive while a memory request is still outstanding.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   PCSrc[1:0]          next-PC select: 00 PC+4, 01 PCTarget, 10 ALUResult, 11 as 00
//   PCTarget, ALUResult branch/JAL and JALR targets (bits [1:0] are ignored)
//   StallF, FlushD      hold PC and decode register / invalidate decode register
//   imem_req, imem_addr instruction memory request; imem_addr always equals PCF
//   imem_ready          request accepted, imem_rdata valid in the same cycle
//   imem_rdata          instruction word
//   InstrD, PCD, PCPlus4D, ValidD  decode-stage register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    input  logic        StallF,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {StReq, StBuf, StKill} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_word;

    assign redirect = (PCSrc == 2'b01) || (PCSrc == 2'b10);
    assign target   = (PCSrc == 2'b10) ? {ALUResult[31:2], 2'b00} : {PCTarget[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    // Reset gates the request combinationally so nothing is issued while rst is high.
    assign imem_req  = !rst && (state_q != StBuf);
    assign imem_addr = pc_q;

    // Fetch control: PC, skid buffer and saved redirect target.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_d       = skid_q;
        tgt_d        = tgt_q;
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        unique case (state_q)
            StReq: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (!StallF) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = StBuf;
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn; remember where to go once it returns.
                    tgt_d   = target;
                    state_d = StKill;
                end
            end
            StBuf: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = StReq;
                end else if (!StallF) begin
                    deliver      = 1'b1;
                    deliver_word = skid_q;
                    pc_d         = pc_plus4;
                    state_d      = StReq;
                end
            end
            StKill: begin
                if (imem_ready) begin
                    pc_d    = redirect ? target : tgt_q;
                    state_d = StReq;
                end else if (redirect) begin
                    tgt_d = target;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // Decode register: flush beats stall beats delivery; otherwise insert a bubble.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        if (FlushD) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
        end else if (StallF) begin
            valid_d = valid_q;
        end else if (deliver) begin
            valid_d = 1'b1;
            instr_d = deliver_word;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            skid_q  <= 32'd0;
            tgt_q   <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] PCTarget = 32'd0;
    logic [31:0] ALUResult = 32'd0;
    logic        StallF = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrc     (PCSrc),
        .PCTarget  (PCTarget),
        .ALUResult (ALUResult),
        .StallF    (StallF),
        .FlushD    (FlushD),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcp4;
    } dec_t;

    int   checks = 0;
    int   errors = 0;
    dec_t exp_q[$];

    // Reference model: fetch pointer, whether a fetched word is parked waiting
    // for the stall to clear, and whether the in-flight request is to be thrown away.
    logic [31:0] m_pc;
    bit          m_parked;
    bit          m_doomed;
    logic [31:0] m_next;
    dec_t        m_dec;

    // Memory contents are a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h9BD1} + 32'h0101_0100;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_parked = 0;
        m_doomed = 0;
        m_next   = 32'd0;
        m_dec    = '{v: 1'b0, instr: NOP, pcd: 32'd0, pcp4: 32'd0};
    endtask

    // One clock of stimulus; the expected decode register after the next edge is queued.
    task automatic step(input bit rdy, input logic [1:0] src, input logic [31:0] tgt,
                        input logic [31:0] alu, input bit st, input bit fl);
        bit          redir;
        bit          dlv;
        logic [31:0] t;
        logic [31:0] cur;
        @(negedge clk);
        imem_ready = rdy;
        PCSrc      = src;
        PCTarget   = tgt;
        ALUResult  = alu;
        StallF     = st;
        FlushD     = fl;
        imem_rdata = rdy ? mem_word(imem_addr) : $urandom;
        #1;
        check32("imem_addr", imem_addr, m_pc);
        check32("imem_req", {31'd0, imem_req}, {31'd0, !m_parked});
        redir = (src == 2'b01) || (src == 2'b10);
        t     = ((src == 2'b10) ? alu : tgt) & 32'hFFFF_FFFC;
        cur   = m_pc;
        dlv   = 0;
        if (m_doomed) begin
            if (rdy) begin
                m_pc     = redir ? t : m_next;
                m_doomed = 0;
            end else if (redir) begin
                m_next = t;
            end
        end else if (m_parked) begin
            if (redir) begin
                m_pc     = t;
                m_parked = 0;
            end else if (!st) begin
                dlv      = 1;
                m_pc     = cur + 32'd4;
                m_parked = 0;
            end
        end else if (rdy) begin
            if (redir)    m_pc = t;
            else if (!st) begin dlv = 1; m_pc = cur + 32'd4; end
            else          m_parked = 1;
        end else if (redir) begin
            m_doomed = 1;
            m_next   = t;
        end
        if (fl)       m_dec = '{v: 1'b0, instr: NOP, pcd: 32'd0, pcp4: 32'd0};
        else if (st)  m_dec = m_dec;
        else if (dlv) m_dec = '{v: 1'b1, instr: mem_word(cur), pcd: cur, pcp4: cur + 32'd4};
        else begin
            m_dec.v     = 1'b0;
            m_dec.instr = NOP;
        end
        exp_q.push_back(m_dec);
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        check32({tag, " imem_addr"}, imem_addr, RESET_PC);
        check32({tag, " ValidD"}, {31'd0, ValidD}, 32'd0);
        check32({tag, " InstrD"}, InstrD, NOP);
        check32({tag, " PCD"}, PCD, 32'd0);
        check32({tag, " PCPlus4D"}, PCPlus4D, 32'd0);
    endtask

    // Assert reset between clock edges and check outputs before the next edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        imem_ready = 1'b0;
        PCSrc      = 2'b00;
        StallF     = 1'b0;
        FlushD     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    // Monitor: compare the decode register after every modelled edge.
    initial begin
        dec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("ValidD", {31'd0, ValidD}, {31'd0, e.v});
                check32("InstrD", InstrD, e.instr);
                check32("PCD", PCD, e.pcd);
                check32("PCPlus4D", PCPlus4D, e.pcp4);
            end
        end
    end

    initial begin
        bit          rdy;
        bit          st;
        bit          fl;
        logic [1:0]  src;
        int unsigned r;
        model_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait streaming from RESET_PC up to 0x10.
        repeat (4) step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // Three wait states at 0x10, then the word arrives.
        repeat (3) step(0, 2'b00, 32'd0, 32'd0, 0, 0);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // Up to 0x20, then stall as the word returns; skid holds it.
        repeat (3) step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        step(1, 2'b00, 32'd0, 32'd0, 1, 0);
        step(1, 2'b00, 32'd0, 32'd0, 1, 0);
        step(0, 2'b00, 32'd0, 32'd0, 1, 0);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // Up to 0x40, redirect to 0x103 while the request is pending.
        repeat (7) step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        step(0, 2'b01, 32'h103, 32'd0, 0, 0);
        step(0, 2'b00, 32'd0, 32'd0, 0, 0);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // JALR to 0x200 with flush.
        step(1, 2'b10, 32'd0, 32'h200, 0, 1);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // PC wrap at the top of the address space.
        step(1, 2'b01, 32'hFFFF_FFFE, 32'd0, 0, 0);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // Redirect plus stall; redirect in a skid state; PCSrc=11.
        step(1, 2'b01, 32'h300, 32'd0, 1, 0);
        step(1, 2'b00, 32'd0, 32'd0, 1, 0);
        step(0, 2'b10, 32'd0, 32'h404, 0, 0);
        step(1, 2'b11, 32'h999, 32'h777, 0, 0);
        // Redirect in the kill state coinciding with ready: newest wins.
        step(0, 2'b01, 32'h500, 32'd0, 0, 0);
        step(0, 2'b01, 32'h600, 32'd0, 0, 0);
        step(1, 2'b10, 32'd0, 32'h700, 0, 0);
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        // Reset while in the skid state and while killing.
        step(1, 2'b00, 32'd0, 32'd0, 1, 0);
        async_reset("reset in skid");
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);
        step(0, 2'b01, 32'h800, 32'd0, 0, 0);
        async_reset("reset in kill");
        step(1, 2'b00, 32'd0, 32'd0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 99) < 65);
            st  = ($urandom_range(0, 99) < 25);
            fl  = ($urandom_range(0, 99) < 10);
            r   = $urandom_range(0, 99);
            src = (r < 75) ? 2'b00 : (r < 86) ? 2'b01 : (r < 96) ? 2'b10 : 2'b11;
            step(rdy, src, $urandom, $urandom, st, fl);
        end

        @(posedge clk);
        #3;
        check32("scoreboard drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
